// File: rtl/osc_clk_src_ctrl_if.sv
// rtl/osc_clk_src_ctrl_if.sv - control/status bundle between the oscillator source controller and its environment
//
// Purpose: groups the source-controller inputs (enable, crystal toggle, CCC lock,
// fault clear) and its outputs (mux select, CCC reset, clock-ok, fault, state).
// Modports:
//   master - environment side: drives enable/xtl_tog/ccc_lock/fault_clr, observes status
//   slave  - controller side: observes the inputs, drives sel_xtl/ccc_rst/clk_ok/fault/state
`timescale 1ns/1ps

interface osc_clk_src_ctrl_if;
    logic       enable;
    logic       xtl_tog;
    logic       ccc_lock;
    logic       fault_clr;
    logic       sel_xtl;
    logic       ccc_rst;
    logic       clk_ok;
    logic       fault;
    logic [2:0] state;

    modport master (
        output enable, xtl_tog, ccc_lock, fault_clr,
        input  sel_xtl, ccc_rst, clk_ok, fault, state
    );

    modport slave (
        input  enable, xtl_tog, ccc_lock, fault_clr,
        output sel_xtl, ccc_rst, clk_ok, fault, state
    );
endinterface

// File: rtl/osc_clk_src_ctrl.sv
// rtl/osc_clk_src_ctrl.sv - crystal qualification and clock-source switching controller
//
// Purpose: runs on the RC oscillator clock, qualifies the crystal by counting its
// (XTL/2) toggle edges over fixed windows, switches the fabric clock mux to the
// crystal after GOOD_WINDOWS consecutive good windows, sequences the CCC reset and
// lock, and falls back to RC on crystal failure or lock timeout with a sticky fault.
// Ports:
//   clk  - RC oscillator clock, sole clock
//   rst  - asynchronous active-high reset
//   bus  - osc_clk_src_ctrl_if.slave: enable, xtl_tog, ccc_lock, fault_clr in;
//          sel_xtl, ccc_rst, clk_ok, fault, state[2:0] out
`timescale 1ns/1ps

module osc_clk_src_ctrl #(
    parameter int WINDOW_CYCLES  = 1024,
    parameter int MIN_EDGES      = 400,
    parameter int MAX_EDGES      = 420,
    parameter int GOOD_WINDOWS   = 4,
    parameter int CCC_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 4096
) (
    input  logic               clk,
    input  logic               rst,
    osc_clk_src_ctrl_if.slave  bus
);

    localparam int WIN_W  = $clog2(WINDOW_CYCLES + 1);
    localparam int EDGE_W = $clog2(MAX_EDGES + 2);
    localparam int GOOD_W = $clog2(GOOD_WINDOWS + 1);
    localparam int RST_W  = $clog2(CCC_RST_CYCLES + 1);
    localparam int LOCK_W = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [EDGE_W-1:0] EDGE_SAT  = EDGE_W'(MAX_EDGES + 1);
    localparam logic [EDGE_W-1:0] EDGE_MIN  = EDGE_W'(MIN_EDGES);
    localparam logic [EDGE_W-1:0] EDGE_MAX  = EDGE_W'(MAX_EDGES);
    localparam logic [GOOD_W-1:0] GOOD_SAT  = GOOD_W'(GOOD_WINDOWS);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(CCC_RST_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RC_RST   = 3'd1,
        S_RC_LOCK  = 3'd2,
        S_RC_RUN   = 3'd3,
        S_XTL_RST  = 3'd4,
        S_XTL_LOCK = 3'd5,
        S_XTL_RUN  = 3'd6,
        S_FALLBACK = 3'd7
    } state_t;

    state_t state;

    // crystal toggle synchroniser and edge detect
    logic xtl_s1, xtl_s2, xtl_s3;
    logic edge_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xtl_s1 <= 1'b0;
            xtl_s2 <= 1'b0;
            xtl_s3 <= 1'b0;
        end else begin
            xtl_s1 <= bus.xtl_tog;
            xtl_s2 <= xtl_s1;
            xtl_s3 <= xtl_s2;
        end
    end

    assign edge_pulse = xtl_s2 ^ xtl_s3;

    // measurement window
    logic [WIN_W-1:0] win_cnt;
    logic             win_last;

    assign win_last = (win_cnt == WIN_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt <= '0;
        end else if (!bus.enable || win_last) begin
            win_cnt <= '0;
        end else begin
            win_cnt <= win_cnt + WIN_W'(1);
        end
    end

    // edge counter; edge_next already includes this cycle's edge so the
    // terminal-cycle edge takes part in the window verdict
    logic [EDGE_W-1:0] edge_cnt;
    logic [EDGE_W-1:0] edge_next;
    logic              win_done;
    logic              win_good;

    always_comb begin
        edge_next = edge_cnt;
        if (edge_pulse && (edge_cnt != EDGE_SAT)) begin
            edge_next = edge_cnt + EDGE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
            win_done <= 1'b0;
            win_good <= 1'b0;
        end else if (!bus.enable) begin
            edge_cnt <= '0;
            win_done <= 1'b0;
        end else if (win_last) begin
            edge_cnt <= '0;
            win_done <= 1'b1;
            win_good <= (edge_next >= EDGE_MIN) && (edge_next <= EDGE_MAX);
        end else begin
            edge_cnt <= edge_next;
            win_done <= 1'b0;
        end
    end

    // consecutive good windows; held at zero while disabled, while a fault is
    // pending (so qualification restarts from scratch after fault_clr) and on fallback
    logic [GOOD_W-1:0] good_cnt;
    logic              fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            good_cnt <= '0;
        end else if (!bus.enable || fault || (state == S_FALLBACK)) begin
            good_cnt <= '0;
        end else if (win_done) begin
            if (!win_good) begin
                good_cnt <= '0;
            end else if (good_cnt != GOOD_SAT) begin
                good_cnt <= good_cnt + GOOD_W'(1);
            end
        end
    end

    // source sequencing FSM
    logic              sel_xtl;
    logic              ccc_rst;
    logic              clk_ok;
    logic [RST_W-1:0]  rst_cnt;
    logic [LOCK_W-1:0] lock_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            sel_xtl  <= 1'b0;
            ccc_rst  <= 1'b1;
            clk_ok   <= 1'b0;
            fault    <= 1'b0;
            rst_cnt  <= '0;
            lock_cnt <= '0;
        end else begin
            // a fault set later in this block overrides the clear
            if (bus.fault_clr) begin
                fault <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    ccc_rst <= 1'b1;
                    rst_cnt <= '0;
                    state   <= S_RC_RST;
                end
                S_RC_RST: begin
                    if (rst_cnt == RST_LAST) begin
                        ccc_rst  <= 1'b0;
                        lock_cnt <= '0;
                        state    <= S_RC_LOCK;
                    end else begin
                        rst_cnt <= rst_cnt + RST_W'(1);
                    end
                end
                S_RC_LOCK: begin
                    if (bus.ccc_lock) begin
                        clk_ok <= 1'b1;
                        state  <= S_RC_RUN;
                    end else if (lock_cnt == LOCK_LAST) begin
                        fault   <= 1'b1;
                        ccc_rst <= 1'b1;
                        rst_cnt <= '0;
                        state   <= S_RC_RST;
                    end else begin
                        lock_cnt <= lock_cnt + LOCK_W'(1);
                    end
                end
                S_RC_RUN: begin
                    if (bus.enable && (good_cnt == GOOD_SAT) && !fault) begin
                        sel_xtl <= 1'b1;
                        ccc_rst <= 1'b1;
                        clk_ok  <= 1'b0;
                        rst_cnt <= '0;
                        state   <= S_XTL_RST;
                    end
                end
                S_XTL_RST: begin
                    if (!bus.enable) begin
                        sel_xtl <= 1'b0;
                        state   <= S_FALLBACK;
                    end else if (rst_cnt == RST_LAST) begin
                        ccc_rst  <= 1'b0;
                        lock_cnt <= '0;
                        state    <= S_XTL_LOCK;
                    end else begin
                        rst_cnt <= rst_cnt + RST_W'(1);
                    end
                end
                S_XTL_LOCK: begin
                    if (!bus.enable) begin
                        sel_xtl <= 1'b0;
                        ccc_rst <= 1'b1;
                        state   <= S_FALLBACK;
                    end else if (bus.ccc_lock) begin
                        clk_ok <= 1'b1;
                        state  <= S_XTL_RUN;
                    end else if (lock_cnt == LOCK_LAST) begin
                        fault   <= 1'b1;
                        sel_xtl <= 1'b0;
                        ccc_rst <= 1'b1;
                        state   <= S_FALLBACK;
                    end else begin
                        lock_cnt <= lock_cnt + LOCK_W'(1);
                    end
                end
                S_XTL_RUN: begin
                    if ((win_done && !win_good) || !bus.ccc_lock) begin
                        fault   <= 1'b1;
                        sel_xtl <= 1'b0;
                        clk_ok  <= 1'b0;
                        ccc_rst <= 1'b1;
                        state   <= S_FALLBACK;
                    end else if (!bus.enable) begin
                        sel_xtl <= 1'b0;
                        clk_ok  <= 1'b0;
                        ccc_rst <= 1'b1;
                        state   <= S_FALLBACK;
                    end
                end
                S_FALLBACK: begin
                    sel_xtl <= 1'b0;
                    clk_ok  <= 1'b0;
                    ccc_rst <= 1'b1;
                    rst_cnt <= '0;
                    state   <= S_RC_RST;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.sel_xtl = sel_xtl;
    assign bus.ccc_rst = ccc_rst;
    assign bus.clk_ok  = clk_ok;
    assign bus.fault   = fault;
    assign bus.state   = state;

endmodule

// File: tb/tb_osc_clk_src_ctrl.sv
// tb/tb_osc_clk_src_ctrl.sv - directed self-checking bench for osc_clk_src_ctrl
`timescale 1ns/1ps

module tb_osc_clk_src_ctrl;

    logic clk;
    logic rst;

    osc_clk_src_ctrl_if bus ();

    osc_clk_src_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int n;

    // 50 MHz RC clock
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // crystal toggle generator: half period in ns (50 -> 410 edges/window,
    // 67 -> ~306, 40 -> 512)
    int  xtl_half = 50;
    bit  xtl_on   = 1'b0;

    initial begin
        bus.xtl_tog = 1'b0;
        #3;
        forever begin
            if (xtl_on) begin
                #(xtl_half);
                bus.xtl_tog = ~bus.xtl_tog;
            end else begin
                #1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget,
                              input string tag, output int cycles);
        cycles = 0;
        while ((bus.state !== target) && (cycles < budget)) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checks++;
        assert (bus.state === target) else begin
            errors++;
            $error("FAIL %s: state observed %0d expected %0d after %0d cycles",
                   tag, bus.state, target, cycles);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.enable    = 1'b0;
        bus.ccc_lock  = 1'b0;
        bus.fault_clr = 1'b0;
        tick(3);

        // reset values
        check("rst_sel_xtl", bus.sel_xtl, 0);
        check("rst_ccc_rst", bus.ccc_rst, 1);
        check("rst_clk_ok",  bus.clk_ok,  0);
        check("rst_fault",   bus.fault,   0);
        check("rst_state",   bus.state,   0);

        // RC bring-up: CCC_RST held 16 cycles in RC_RST, lock at cycle 30
        rst = 1'b0;
        tick(16);
        check("rc_rst_held", bus.ccc_rst, 1);
        check("rc_rst_state", bus.state, 1);
        tick(1);
        check("rc_rst_release", bus.ccc_rst, 0);
        check("rc_lock_state", bus.state, 2);
        tick(13);
        bus.ccc_lock = 1'b1;
        tick(1);
        check("rc_run_state",  bus.state,   3);
        check("rc_run_clk_ok", bus.clk_ok,  1);
        check("rc_run_sel",    bus.sel_xtl, 0);
        check("rc_run_fault",  bus.fault,   0);

        // qualify a 410-edge crystal: switch after the 4th good window
        bus.enable = 1'b1;
        xtl_on     = 1'b1;
        wait_state(3'd4, 4300, "xtl_switch", n);
        check("xtl_switch_min_cycles", n >= 4096, 1);
        check("xtl_switch_max_cycles", n <= 4100, 1);
        check("xtl_rst_sel",    bus.sel_xtl, 1);
        check("xtl_rst_ccc",    bus.ccc_rst, 1);
        check("xtl_rst_clk_ok", bus.clk_ok,  0);
        bus.ccc_lock = 1'b0;
        wait_state(3'd5, 20, "xtl_lock_entry", n);
        check("xtl_rst_len", n, 16);
        check("xtl_lock_ccc", bus.ccc_rst, 0);
        tick(10);
        check("xtl_lock_wait", bus.state, 5);
        bus.ccc_lock = 1'b1;
        tick(1);
        check("xtl_run_state",  bus.state,  6);
        check("xtl_run_clk_ok", bus.clk_ok, 1);

        // crystal dies: fault and fallback at the end of the window
        xtl_on = 1'b0;
        wait_state(3'd7, 1100, "xtl_dead_fallback", n);
        check("fb_fault",  bus.fault,   1);
        check("fb_sel",    bus.sel_xtl, 0);
        check("fb_clk_ok", bus.clk_ok,  0);
        tick(1);
        check("fb_to_rc_rst", bus.state, 1);
        xtl_on = 1'b1;
        wait_state(3'd3, 100, "fb_rc_run", n);
        tick(6000);
        check("fault_blocks_state", bus.state,   3);
        check("fault_blocks_sel",   bus.sel_xtl, 0);
        check("fault_blocks_good",  dut.good_cnt, 0);
        bus.fault_clr = 1'b1;
        tick(1);
        bus.fault_clr = 1'b0;
        check("fault_cleared", bus.fault, 0);
        wait_state(3'd4, 5300, "reswitch", n);
        check("reswitch_needs_windows", n >= 3 * 1024, 1);
        wait_state(3'd6, 40, "reswitch_run", n);

        // ENABLE=0 in XTL_RUN: fallback without fault
        bus.enable = 1'b0;
        wait_state(3'd7, 3, "disable_fallback", n);
        check("disable_no_fault", bus.fault,   0);
        check("disable_sel",      bus.sel_xtl, 0);
        wait_state(3'd3, 100, "disable_rc_run", n);

        // out-of-range crystals never qualify
        xtl_half   = 67;
        bus.enable = 1'b1;
        tick(5200);
        check("slow_xtl_state", bus.state,    3);
        check("slow_xtl_sel",   bus.sel_xtl,  0);
        check("slow_xtl_good",  dut.good_cnt, 0);
        xtl_half = 40;
        tick(5200);
        check("fast_xtl_state", bus.state,    3);
        check("fast_xtl_sel",   bus.sel_xtl,  0);
        check("fast_xtl_good",  dut.good_cnt, 0);

        // lock timeout in XTL_LOCK
        xtl_half = 50;
        wait_state(3'd4, 5 * 1024 + 100, "lock_to_switch", n);
        bus.ccc_lock = 1'b0;
        wait_state(3'd5, 20, "lock_to_lock", n);
        wait_state(3'd7, 4200, "lock_to_fallback", n);
        check("lock_timeout_cycles", n, 4096);
        check("lock_to_fault",  bus.fault,   1);
        check("lock_to_sel",    bus.sel_xtl, 0);
        bus.ccc_lock = 1'b1;
        wait_state(3'd3, 100, "lock_to_rc_run", n);
        check("lock_to_clk_ok", bus.clk_ok, 1);

        // asynchronous reset in the middle of XTL_RST
        bus.fault_clr = 1'b1;
        tick(1);
        bus.fault_clr = 1'b0;
        wait_state(3'd4, 5300, "mid_rst_switch", n);
        tick(5);
        #4;
        rst = 1'b1;
        #1;
        check("async_rst_state",  bus.state,   0);
        check("async_rst_sel",    bus.sel_xtl, 0);
        check("async_rst_ccc",    bus.ccc_rst, 1);
        check("async_rst_clk_ok", bus.clk_ok,  0);
        check("async_rst_fault",  bus.fault,   0);
        tick(2);
        rst = 1'b0;
        tick(1);
        check("restart_rc_rst", bus.state, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/osc_clk_src_ctrl.md
Name: osc_clk_src_ctrl

Overview:
- Clock-source controller for the on-chip oscillator block; runs on the RC 25/50 MHz oscillator clock.
- Qualifies the crystal oscillator by counting its edges over fixed windows.
- Switches the fabric clock mux select to the crystal only after qualification, and sequences the downstream CCC reset/lock.
- Falls back to the RC source on crystal failure or CCC lock timeout, and latches a sticky fault flag for firmware.

Parameters:
- WINDOW_CYCLES, 1024: measurement window length in CLK cycles.
- MIN_EDGES, 400: minimum XTL_TOG edges (rise+fall) per window for a good window.
- MAX_EDGES, 420: maximum XTL_TOG edges per window for a good window.
- GOOD_WINDOWS, 4: consecutive good windows required before switching to XTL.
- CCC_RST_CYCLES, 16: cycles CCC_RST is held after a source switch.
- LOCK_TIMEOUT, 4096: cycles allowed for CCC_LOCK after CCC_RST release.

Ports:
- CLK  in  1  RC oscillator clock (50 MHz); sole clock.
- RESET  in  1  asynchronous, active-high reset.
- ENABLE  in  1  1 = qualification and switching permitted; 0 forces RC.
- XTL_TOG  in  1  asynchronous crystal-derived toggle (XTL/2); synchronised internally.
- CCC_LOCK  in  1  CCC lock indication (CLK domain).
- FAULT_CLR  in  1  single-cycle pulse that clears FAULT.
- SEL_XTL  out  1  mux select: 1 = crystal, 0 = RC.
- CCC_RST  out  1  active-high CCC reset.
- CLK_OK  out  1  selected source is stable and the CCC is locked.
- FAULT  out  1  sticky: crystal failed or lock timed out.
- STATE  out  3  current FSM state encoding, for debug.

Behaviour:
- Reset values: SEL_XTL=0, CCC_RST=1, CLK_OK=0, FAULT=0, STATE=IDLE. Async assert, sync release on CLK; reset mid-operation returns immediately to these values.
- XTL_TOG passes through a 2-flop synchroniser plus an edge-detect flop. Each rise or fall gives a 1-cycle edge pulse, latency 3 cycles from the pin.
- Window counter: free-running 0..WINDOW_CYCLES-1 while ENABLE=1; held at 0 when ENABLE=0.
- Edge counter: clears at window start and saturates at MAX_EDGES+1.
- At the terminal cycle, window_good = (MIN_EDGES <= count <= MAX_EDGES), including the edge on the terminal cycle. window_good is registered and valid for 1 cycle (win_done).
- Good-window counter: increments on win_done&good, clears on win_done&!good, saturates at GOOD_WINDOWS.
- FSM states and encodings:
  - IDLE (0): CCC_RST=1. Goes to RC_RST when entered from reset.
  - RC_RST (1): hold CCC_RST for CCC_RST_CYCLES, then go to RC_LOCK.
  - RC_LOCK (2): wait CCC_LOCK=1, then go to RC_RUN. On timeout, set FAULT and return to RC_RST.
  - RC_RUN (3): CLK_OK=1. When ENABLE=1 and the good counter reaches GOOD_WINDOWS and FAULT=0, set SEL_XTL=1 and go to XTL_RST.
  - XTL_RST (4): SEL_XTL=1, CCC_RST=1 for CCC_RST_CYCLES, then go to XTL_LOCK.
  - XTL_LOCK (5): wait CCC_LOCK, then go to XTL_RUN. On timeout, set FAULT and go to FALLBACK.
  - XTL_RUN (6): CLK_OK=1. A bad window, ENABLE=0, or CCC_LOCK falling sends it to FALLBACK. A bad window or lock loss also sets FAULT; ENABLE=0 does not.
  - FALLBACK (7): SEL_XTL=0 and CLK_OK=0 in the same cycle, clear the good counter, then go to RC_RST.
- CLK_OK is registered and deasserts on the cycle the FSM leaves a RUN state.
- SEL_XTL changes only on entry to XTL_RST (0->1) or FALLBACK (1->0). It never toggles inside a window count.
- While FAULT=1, no switch to XTL. FAULT_CLR clears FAULT; if FAULT_CLR and a new fault occur in the same cycle, the set wins.
- ENABLE=0 in RC states: stay on RC and clear the good counter.
- All counters are sized with clog2 of their parameter + 1; there is no wrap except the window counter.

Test Plan:
- Reset, then CCC_LOCK=1 at cycle 30, XTL_TOG absent -> SEL_XTL=0, CCC_RST low after 16 cycles, CLK_OK=1, STATE=3, FAULT=0.
- ENABLE=1, XTL_TOG at 20 MHz/2 (410 edges/window) -> SEL_XTL=1 after the 4th window (~4096+ cycles), CCC_RST pulses 16 cycles, CLK_OK=1 in STATE=6 once lock is reasserted.
- In XTL_RUN, stop XTL_TOG -> window count 0, FAULT=1, SEL_XTL=0 at end of that window, STATE 7->1; with XTL restored it does not re-switch until a FAULT_CLR pulse, then after 4 good windows.
- XTL at 15 MHz (~307 edges), and separately 25 MHz (~512 edges) -> never leaves RC_RUN; the good counter stays 0.
- In XTL_LOCK, hold CCC_LOCK=0 for 4096 cycles -> FAULT=1, FALLBACK, SEL_XTL=0.
- Assert RESET mid-XTL_RST -> all outputs return to reset values asynchronously; the sequence restarts at IDLE.
